// File: rtl/arcade_input_conditioner.sv
// arcade_input_conditioner: joystick swap, rotation, SOCD cleaning, per-button autofire and
// minimum-width coin pulses between the user_io decode and a core's active-low player ports.
module arcade_input_conditioner #(
   parameter int PLAYERS     = 2,
   parameter int BUTTONS     = 6,
   parameter int CE_DIV      = 24000,
   parameter int COIN_MS     = 50,
   parameter int AUTOFIRE_MS = 33
) (
   input  logic                           clk_sys,
   input  logic                           reset,
   input  logic [PLAYERS*(4+BUTTONS)-1:0] joy_in,
   input  logic [PLAYERS-1:0]             coin_in,
   input  logic [PLAYERS-1:0]             start_in,
   input  logic                           rotate,
   input  logic                           flip,
   input  logic                           joyswap,
   input  logic [PLAYERS*BUTTONS-1:0]     af_en,
   output logic [PLAYERS*(4+BUTTONS)-1:0] joy_out,
   output logic [PLAYERS-1:0]             coin_out,
   output logic [PLAYERS-1:0]             start_out
);

   localparam int W  = 4 + BUTTONS;
   localparam int JW = PLAYERS * W;
   localparam int NB = PLAYERS * BUTTONS;
   localparam int TW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam int PW = (AUTOFIRE_MS > 1) ? $clog2(AUTOFIRE_MS) : 1;

   localparam logic [1:0] COIN_IDLE  = 2'd0;
   localparam logic [1:0] COIN_PULSE = 2'd1;
   localparam logic [1:0] COIN_WAIT  = 2'd2;

   logic [JW-1:0]      joy_sw, joy_s1, joy_next;
   logic [PLAYERS-1:0] coin_sw, coin_s1, coin_prev, coin_rise;
   logic [PLAYERS-1:0] start_sw, start_s1;
   logic [TW-1:0]      tick_cnt;
   logic [PW-1:0]      phase_cnt;
   logic               tick, phase_wrap;
   logic [NB-1:0]      btn_held, btn_prev, btn_rise, af_tog, tog_eff, btn_act;

   if (PLAYERS > 1) begin : g_swap
      always_comb begin
         joy_sw   = joy_in;
         coin_sw  = coin_in;
         start_sw = start_in;
         if (joyswap) begin
            joy_sw[0 +: W] = joy_in[W +: W];
            joy_sw[W +: W] = joy_in[0 +: W];
            coin_sw[0]     = coin_in[1];
            coin_sw[1]     = coin_in[0];
            start_sw[0]    = start_in[1];
            start_sw[1]    = start_in[0];
         end
      end
   end else begin : g_noswap
      assign joy_sw   = joy_in;
      assign coin_sw  = coin_in;
      assign start_sw = start_in;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         joy_s1    <= '0;
         coin_s1   <= '0;
         start_s1  <= '0;
         coin_prev <= '0;
         btn_prev  <= '0;
      end else begin
         joy_s1    <= joy_sw;
         coin_s1   <= coin_sw;
         start_s1  <= start_sw;
         coin_prev <= coin_s1;
         btn_prev  <= btn_held;
      end
   end

   // Free-running ms tick and the shared autofire phase derived from it.
   assign tick       = (tick_cnt == TW'(CE_DIV - 1));
   assign phase_wrap = tick && (phase_cnt == PW'(AUTOFIRE_MS - 1));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tick_cnt  <= '0;
         phase_cnt <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (tick)
            phase_cnt <= phase_wrap ? '0 : phase_cnt + PW'(1);
      end
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_btn
      for (genvar b = 0; b < BUTTONS; b++) begin : g_bit
         assign btn_held[p*BUTTONS+b] = joy_s1[p*W+4+b];
      end
   end

   // A fresh press always starts in the asserted phase, even if a wrap lands on the same cycle.
   assign btn_rise = btn_held & ~btn_prev;
   assign tog_eff  = af_tog & ~btn_rise;
   assign btn_act  = btn_held & ~(af_en & tog_eff);

   always_ff @(posedge clk_sys) begin
      if (reset)
         af_tog <= '0;
      else
         af_tog <= ~btn_rise & (af_tog ^ ({NB{phase_wrap}} & btn_held));
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic u, d, l, r;
      logic ru, rd, rl, rr;
      logic [3:0] dir_clean;
      logic [1:0] coin_state;
      logic [7:0] coin_cnt;

      assign {r, l, d, u} = joy_s1[p*W +: 4];

      always_comb begin
         {ru, rd, rl, rr} = {u, d, l, r};
         if (rotate) begin
            if (!flip)
               {ru, rd, rl, rr} = {l, r, d, u};
            else
               {ru, rd, rl, rr} = {r, l, u, d};
         end
      end

      assign dir_clean = {rr & ~rl, rl & ~rr, rd & ~ru, ru & ~rd};
      assign joy_next[p*W +: W] = {btn_act[p*BUTTONS +: BUTTONS], dir_clean};
      assign coin_rise[p] = coin_s1[p] & ~coin_prev[p];

      // WAIT holds until the coin is released so a stuck coin switch cannot retrigger.
      always_ff @(posedge clk_sys) begin
         if (reset) begin
            coin_state <= COIN_IDLE;
            coin_cnt   <= '0;
         end else begin
            case (coin_state)
               COIN_IDLE: begin
                  if (coin_rise[p]) begin
                     coin_state <= COIN_PULSE;
                     coin_cnt   <= '0;
                  end
               end
               COIN_PULSE: begin
                  if (tick) begin
                     if (coin_cnt == 8'(COIN_MS - 1))
                        coin_state <= COIN_WAIT;
                     else
                        coin_cnt <= coin_cnt + 8'd1;
                  end
               end
               COIN_WAIT: begin
                  if (!coin_s1[p])
                     coin_state <= COIN_IDLE;
               end
               default: coin_state <= COIN_IDLE;
            endcase
         end
      end

      assign coin_out[p] = (coin_state != COIN_PULSE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         joy_out   <= '1;
         start_out <= '1;
      end else begin
         joy_out   <= ~joy_next;
         start_out <= ~start_s1;
      end
   end

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// tb_arcade_input_conditioner: directed and randomized stimulus compared every cycle against a
// cycle-indexed reference model built from input history and ms-tick arithmetic.
module tb_arcade_input_conditioner;

   localparam int PLAYERS     = 2;
   localparam int BUTTONS     = 2;
   localparam int CE_DIV      = 4;
   localparam int COIN_MS     = 3;
   localparam int AUTOFIRE_MS = 2;
   localparam int W           = 4 + BUTTONS;
   localparam int JW          = PLAYERS * W;
   localparam int NB          = PLAYERS * BUTTONS;
   localparam int AF_CYC      = CE_DIV * AUTOFIRE_MS;
   localparam int HMAX        = 4096;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic [JW-1:0] joy_in;
   logic [1:0]    coin_in, start_in;
   logic          rotate, flip, joyswap;
   logic [NB-1:0] af_en;
   logic [JW-1:0] joy_out;
   logic [1:0]    coin_out, start_out;

   arcade_input_conditioner #(
      .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .CE_DIV(CE_DIV),
      .COIN_MS(COIN_MS), .AUTOFIRE_MS(AUTOFIRE_MS)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .joy_in(joy_in), .coin_in(coin_in),
      .start_in(start_in), .rotate(rotate), .flip(flip), .joyswap(joyswap),
      .af_en(af_en), .joy_out(joy_out), .coin_out(coin_out), .start_out(start_out)
   );

   always #5 clk_sys = ~clk_sys;

   // Input history: entry k holds what the DUT sees at the posedge that ends cycle k.
   logic [JW-1:0] h_joy [HMAX];
   logic [1:0]    h_coin [HMAX];
   logic [1:0]    h_start [HMAX];
   logic [NB-1:0] h_af [HMAX];
   logic          h_rot [HMAX], h_flip [HMAX], h_swap [HMAX], h_rst [HMAX];

   int cyc = 0;
   int rst_edge = 0;
   int rise_at [NB];
   int pulse_start [2];
   int pulse_end [2];
   bit pulse_valid [2];
   int compare_count = 0;
   int mismatch_count = 0;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compare_count++;
      if (obs !== exp) begin
         mismatch_count++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [JW-1:0] joy, input logic [1:0] coin,
                                input logic [1:0] start, input logic rot, input logic fl,
                                input logic sw, input logic [NB-1:0] af);
      reset = rst; joy_in = joy; coin_in = coin; start_in = start;
      rotate = rot; flip = fl; joyswap = sw; af_en = af;
   endtask

   // Player-swapped, registered view of the inputs as seen during cycle x.
   function automatic logic [JW-1:0] s1Joy(input int x);
      if (x < 1 || h_rst[x-1]) return '0;
      return h_swap[x-1] ? {h_joy[x-1][W-1:0], h_joy[x-1][JW-1:W]} : h_joy[x-1];
   endfunction

   function automatic logic [1:0] s1Pair(input int x, input bit is_coin);
      logic [1:0] v;
      if (x < 1 || h_rst[x-1]) return 2'b00;
      v = is_coin ? h_coin[x-1] : h_start[x-1];
      return h_swap[x-1] ? {v[0], v[1]} : v;
   endfunction

   // Directions packed {R,L,D,U}; returns the rotated then SOCD-cleaned set.
   function automatic logic [3:0] cleanDirs(input logic [3:0] dv, input logic rot, input logic fl);
      logic u, dn, l, r, ou, od, ol, orr;
      {r, l, dn, u} = dv;
      if (!rot)     begin ou = u; od = dn; ol = l;  orr = r;  end
      else if (!fl) begin ou = l; od = r;  ol = dn; orr = u;  end
      else          begin ou = r; od = l;  ol = u;  orr = dn; end
      if (ol && orr) begin ol = 0; orr = 0; end
      if (ou && od)  begin ou = 0; od = 0;  end
      return {orr, ol, od, ou};
   endfunction

   task automatic modelAndCheck();
      int c = cyc - 1;
      logic [JW-1:0] exp_joy, s, sp;
      logic [1:0] exp_coin, exp_start, cn, cp;
      exp_joy = '1; exp_coin = 2'b11; exp_start = 2'b11;
      if (h_rst[c]) begin
         rst_edge = cyc;
         for (int p = 0; p < 2; p++) begin pulse_valid[p] = 0; pulse_end[p] = -100; end
         for (int k = 0; k < NB; k++) rise_at[k] = -1;
      end else begin
         s = s1Joy(c); sp = s1Joy(c - 1);
         cn = s1Pair(c, 1); cp = s1Pair(c - 1, 1);
         for (int p = 0; p < PLAYERS; p++) begin
            exp_joy[p*W +: 4] = ~cleanDirs(s[p*W +: 4], h_rot[c], h_flip[c]);
            for (int b = 0; b < BUTTONS; b++) begin
               int k = p*BUTTONS + b;
               logic held, par;
               held = s[p*W+4+b];
               par = 0;
               if (held && !sp[p*W+4+b]) rise_at[k] = c;
               // Phase parity = number of autofire wraps strictly after the press, before now.
               if (held && c > rise_at[k])
                  par = 1'(((c - rst_edge) / AF_CYC) - ((rise_at[k] + 1 - rst_edge) / AF_CYC));
               exp_joy[p*W+4+b] = ~(held & ~(h_af[c][k] & par));
            end
            if (cn[p] && !cp[p] && c >= pulse_end[p] + 2) begin
               int ft = c + 1;
               while ((ft - rst_edge) % CE_DIV != CE_DIV - 1) ft++;
               pulse_valid[p] = 1;
               pulse_start[p] = c;
               pulse_end[p]   = ft + CE_DIV * (COIN_MS - 1);
            end
            exp_coin[p] = !(pulse_valid[p] && cyc >= pulse_start[p] + 1 && cyc <= pulse_end[p]);
         end
         exp_start = ~s1Pair(c, 0);
      end
      checkOutput("joy_out", 16'(joy_out), 16'(exp_joy));
      checkOutput("coin_out", 16'(coin_out), 16'(exp_coin));
      checkOutput("start_out", 16'(start_out), 16'(exp_start));
   endtask

   task automatic stepCycle();
      h_joy[cyc] = joy_in; h_coin[cyc] = coin_in; h_start[cyc] = start_in; h_af[cyc] = af_en;
      h_rot[cyc] = rotate; h_flip[cyc] = flip; h_swap[cyc] = joyswap; h_rst[cyc] = reset;
      @(posedge clk_sys);
      cyc++;
      @(negedge clk_sys);
      modelAndCheck();
   endtask

   initial begin
      int lows, falls0, falls1;
      logic prev0, prev1;

      applyStimulus(1, '1, 2'b11, 2'b11, 1, 1, 1, '1);
      repeat (5) stepCycle();
      reset = 0;
      stepCycle();
      checkOutput("rst_release_joy", 16'(joy_out), 16'(12'hFFF));
      applyStimulus(0, '0, 2'b00, 2'b00, 0, 0, 0, '0);
      repeat (20) stepCycle();

      applyStimulus(0, 12'h001, 2'b00, 2'b00, 1, 0, 0, '0);
      repeat (3) stepCycle();
      checkOutput("rot_cw_p1", 16'(joy_out[5:0]), 16'(6'b110111));
      flip = 1;
      repeat (3) stepCycle();
      checkOutput("rot_ccw_p1", 16'(joy_out[5:0]), 16'(6'b111011));

      applyStimulus(0, 12'h00C, 2'b00, 2'b00, 0, 0, 0, '0);
      repeat (3) stepCycle();
      checkOutput("socd_lr", 16'(joy_out[5:0]), 16'(6'b111111));

      applyStimulus(0, 12'h400, 2'b00, 2'b01, 0, 0, 1, '0);
      repeat (3) stepCycle();
      checkOutput("swap_btn_p1", 16'(joy_out[4]), 16'(1'b0));
      checkOutput("swap_btn_p2", 16'(joy_out[10]), 16'(1'b1));
      checkOutput("swap_start", 16'(start_out), 16'(2'b01));

      applyStimulus(0, '0, 2'b00, 2'b00, 0, 0, 0, '0);
      repeat (6) stepCycle();
      coin_in = 2'b01;
      stepCycle();
      coin_in = 2'b00;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (!coin_out[0]) lows++;
      end
      checkOutput("coin_width_ok", 16'(lows >= 9 && lows <= 12), 16'd1);

      coin_in = 2'b01;
      falls0 = 0; prev0 = coin_out[0];
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         if (prev0 && !coin_out[0]) falls0++;
         prev0 = coin_out[0];
      end
      checkOutput("coin_held_once", 16'(falls0), 16'd1);

      coin_in = 2'b00;
      repeat (10) stepCycle();
      coin_in = 2'b01;
      repeat (5) stepCycle();
      reset = 1;
      stepCycle();
      checkOutput("coin_rst_abort", 16'(coin_out[0]), 16'(1'b1));
      applyStimulus(0, '0, 2'b00, 2'b00, 0, 0, 0, '0);
      repeat (10) stepCycle();

      applyStimulus(0, 12'h010, 2'b00, 2'b00, 0, 0, 0, 4'b0001);
      repeat (64) stepCycle();
      joy_in = '0;
      repeat (2) stepCycle();
      checkOutput("af_release", 16'(joy_out[4]), 16'(1'b1));
      applyStimulus(0, 12'h010, 2'b00, 2'b00, 0, 0, 0, 4'b0000);
      lows = 0;
      for (int i = 0; i < 24; i++) begin
         stepCycle();
         if (i >= 2 && !joy_out[4]) lows++;
      end
      checkOutput("af_off_solid", 16'(lows), 16'd22);

      applyStimulus(0, '0, 2'b11, 2'b00, 0, 0, 0, '0);
      repeat (25) stepCycle();
      falls0 = 0; falls1 = 0; prev0 = coin_out[0]; prev1 = coin_out[1];
      for (int i = 0; i < 40; i++) begin
         if (i % 4 == 0) joyswap = ~joyswap;
         stepCycle();
         if (prev0 && !coin_out[0]) falls0++;
         if (prev1 && !coin_out[1]) falls1++;
         prev0 = coin_out[0]; prev1 = coin_out[1];
      end
      checkOutput("swap_race_p1", 16'(falls0), 16'd0);
      checkOutput("swap_race_p2", 16'(falls1), 16'd0);

      applyStimulus(0, '0, 2'b00, 2'b00, 0, 0, 0, '0);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0)   joy_in   = JW'($urandom);
         if ($urandom_range(0, 19) == 0)  coin_in  = 2'($urandom);
         if ($urandom_range(0, 9) == 0)   start_in = 2'($urandom);
         if ($urandom_range(0, 49) == 0)  rotate   = 1'($urandom);
         if ($urandom_range(0, 49) == 0)  flip     = 1'($urandom);
         if ($urandom_range(0, 59) == 0)  joyswap  = 1'($urandom);
         if ($urandom_range(0, 29) == 0)  af_en    = NB'($urandom);
         reset = ($urandom_range(0, 399) == 0);
         stepCycle();
      end
      reset = 0;
      repeat (4) stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
